// File: rtl/sparc_pipe_pkg.sv
// Shared definitions for the SPARC integer pipeline: issue-controller state and
// fixed architectural constants.
package sparc_pipe_pkg;

    typedef enum logic [0:0] {RUN, DRAIN} sb_state_t;

    localparam logic [4:0]  REG_G0   = 5'd0;
    localparam logic [31:0] NOP_INST = 32'h01000000;

endpackage

// File: rtl/sb_reg_counter.sv
// Outstanding-write counter for one architectural register. A retire with an empty
// counter is reported on underflow and leaves the count at zero.
module sb_reg_counter #(
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             nonzero,
    output logic             underflow
);

    logic dec_eff;

    assign nonzero   = (cnt != '0);
    assign full      = (cnt == CNT_W'(MAX_INFLIGHT));
    assign dec_eff   = dec & nonzero;
    assign underflow = dec & ~nonzero;

    // inc and dec together cancel, so plain add/subtract covers every case
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(inc) - CNT_W'(dec_eff);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage issue controller: holds back instructions whose operands have writes in
// flight, limits outstanding writes per register, and sequences a drain on flush.
module hazard_scoreboard
    import sparc_pipe_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = 2,
    parameter int TOT_W        = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  id_use_rd,
    input  logic                  id_wr_rd,
    input  logic                  ex_ready,
    input  logic                  WB_reg_en,
    input  logic [REG_ADDR_W-1:0] WB_regD_out,
    input  logic                  flush_req,
    output logic                  issue_fire,
    output logic                  issue_stall,
    output logic                  drain_done,
    output logic [NUM_REGS-1:0]   pending_mask,
    output logic                  sb_underflow
);

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] full;
    logic [NUM_REGS-1:0] nonzero;
    logic [NUM_REGS-1:0] uf_ev;
    logic [TOT_W-1:0]    total;
    logic                hazard;
    logic                inc_any;
    logic                dec_any;
    sb_state_t           state_q, state_d;

    // %g0 is hardwired: never pending, never full, never underflows
    assign cnt[0]     = '0;
    assign full[0]    = 1'b0;
    assign nonzero[0] = 1'b0;
    assign uf_ev[0]   = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        sb_reg_counter #(
            .MAX_INFLIGHT (MAX_INFLIGHT),
            .CNT_W        (CNT_W)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc_any && (id_rd == REG_ADDR_W'(r))),
            .dec       (WB_reg_en && (WB_regD_out == REG_ADDR_W'(r))),
            .cnt       (cnt[r]),
            .full      (full[r]),
            .nonzero   (nonzero[r]),
            .underflow (uf_ev[r])
        );
    end

    // Registered counters only: a retire releases a stall on the following cycle
    assign hazard = (id_use_rs1 & nonzero[id_rs1])
                  | (id_use_rs2 & nonzero[id_rs2])
                  | (id_use_rd  & nonzero[id_rd])
                  | (id_wr_rd   & full[id_rd]);

    assign issue_fire   = id_valid & ex_ready & ~hazard & (state_q == RUN) & ~flush_req;
    assign issue_stall  = id_valid & ~issue_fire;
    assign pending_mask = nonzero;

    assign inc_any = issue_fire & id_wr_rd & (id_rd != REG_ADDR_W'(REG_G0));
    assign dec_any = WB_reg_en & (cnt[WB_regD_out] != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            total        <= '0;
            sb_underflow <= 1'b0;
            state_q      <= RUN;
        end else begin
            total   <= total + TOT_W'(inc_any) - TOT_W'(dec_any);
            state_q <= state_d;
            if (|uf_ev) sb_underflow <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        drain_done = 1'b0;
        case (state_q)
            RUN: begin
                if (flush_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (total == '0) begin
                    state_d    = RUN;
                    drain_done = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a per-register outstanding-count model.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_use_rd, id_wr_rd;
    logic        ex_ready;
    logic        WB_reg_en;
    logic [4:0]  WB_regD_out;
    logic        flush_req;
    logic        issue_fire, issue_stall, drain_done, sb_underflow;
    logic [31:0] pending_mask;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // reference model: outstanding writes per register, drain flag, sticky error
    int m_cnt [32];
    bit m_drain;
    bit m_uf;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_use_rd    (id_use_rd),
        .id_wr_rd     (id_wr_rd),
        .ex_ready     (ex_ready),
        .WB_reg_en    (WB_reg_en),
        .WB_regD_out  (WB_regD_out),
        .flush_req    (flush_req),
        .issue_fire   (issue_fire),
        .issue_stall  (issue_stall),
        .drain_done   (drain_done),
        .pending_mask (pending_mask),
        .sb_underflow (sb_underflow)
    );

    function automatic int m_total();
        int s = 0;
        for (int r = 1; r < 32; r++) s += m_cnt[r];
        return s;
    endfunction

    function automatic bit m_fire();
        bit hz;
        hz = (id_use_rs1 && id_rs1 != 0 && m_cnt[id_rs1] > 0)
          || (id_use_rs2 && id_rs2 != 0 && m_cnt[id_rs2] > 0)
          || (id_use_rd  && id_rd  != 0 && m_cnt[id_rd]  > 0)
          || (id_wr_rd   && id_rd  != 0 && m_cnt[id_rd]  == 3);
        return id_valid && ex_ready && !hz && !m_drain && !flush_req;
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m = '0;
        for (int r = 1; r < 32; r++) m[r] = (m_cnt[r] > 0);
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model advances on every active edge from the inputs presented in that cycle
    always @(posedge clk) begin
        bit fire;
        bit leave_drain;
        fire        = m_fire();
        leave_drain = m_drain && (m_total() == 0);
        if (reset) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
            m_drain = 1'b0;
            m_uf    = 1'b0;
        end else begin
            if (WB_reg_en && WB_regD_out != 0) begin
                if (m_cnt[WB_regD_out] == 0) m_uf = 1'b1;
                else m_cnt[WB_regD_out]--;
            end
            if (fire && id_wr_rd && id_rd != 0) m_cnt[id_rd]++;
            if (!m_drain && flush_req) m_drain = 1'b1;
            else if (leave_drain) m_drain = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit f;
            f = m_fire();
            check("issue_fire",   32'(issue_fire),   32'(f));
            check("issue_stall",  32'(issue_stall),  32'(id_valid && !f));
            check("drain_done",   32'(drain_done),   32'(m_drain && m_total() == 0));
            check("pending_mask", pending_mask,      m_mask());
            check("sb_underflow", 32'(sb_underflow), 32'(m_uf));
        end
    end

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_use_rd = 0; id_wr_rd = 0;
        ex_ready = 1; WB_reg_en = 0; WB_regD_out = 0; flush_req = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_wr(input int rd);
        id_valid = 1; id_wr_rd = 1; id_rd = 5'(rd);
        id_use_rs1 = 0; id_use_rs2 = 0; id_use_rd = 0;
    endtask

    task automatic retire(input int rd);
        WB_reg_en = 1; WB_regD_out = 5'(rd);
    endtask

    initial begin
        reset = 1;
        idle();
        for (int i = 0; i < 3; i++) @(posedge clk);
        #1;
        reset = 0;
        chk_en = 1;
        #1;
        check("rst_mask", pending_mask, 32'h0);
        check("rst_underflow", 32'(sb_underflow), 32'h0);
        check("rst_drain_done", 32'(drain_done), 32'h0);
        check("rst_fire", 32'(issue_fire), 32'h0);

        // RAW on r5, released the cycle after its retire
        issue_wr(5);
        #1 check("t1_fire_wr", 32'(issue_fire), 32'h1);
        tick();
        idle(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 5;
        #1 check("t1_stall", 32'(issue_stall), 32'h1);
        check("t1_mask5", 32'(pending_mask[5]), 32'h1);
        tick();
        retire(5);
        #1 check("t1_stall_retire_cycle", 32'(issue_stall), 32'h1);
        tick();
        WB_reg_en = 0;
        #1 check("t1_fire_after", 32'(issue_fire), 32'h1);
        check("t1_mask5_clear", 32'(pending_mask[5]), 32'h0);
        tick();

        // three writes fill r7; the fourth waits for one retire
        idle();
        for (int i = 0; i < 3; i++) begin
            issue_wr(7);
            tick();
        end
        #1 check("t2_full_stall", 32'(issue_stall), 32'h1);
        retire(7);
        tick();
        WB_reg_en = 0;
        #1 check("t2_fire_after", 32'(issue_fire), 32'h1);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            retire(7);
            tick();
        end
        idle();
        #1 check("t2_mask7_clear", 32'(pending_mask[7]), 32'h0);

        // simultaneous issue and retire on r9 cancel out
        issue_wr(9);
        tick();
        retire(9);
        tick();
        idle();
        #1 check("t3_mask9_held", 32'(pending_mask[9]), 32'h1);
        retire(9);
        tick();
        idle();
        #1 check("t3_mask9_clear", 32'(pending_mask[9]), 32'h0);

        // %g0 never stalls; retiring an idle register raises the sticky error
        issue_wr(0); id_use_rs1 = 1; id_rs1 = 0;
        #1 check("t4_g0_fire", 32'(issue_fire), 32'h1);
        tick();
        idle();
        retire(12);
        tick();
        idle();
        #1 check("t4_underflow", 32'(sb_underflow), 32'h1);
        check("t4_mask0", 32'(pending_mask[0]), 32'h0);
        tick();
        check("t4_underflow_sticky", 32'(sb_underflow), 32'h1);

        // drain with r3, r4 outstanding
        issue_wr(3); tick();
        issue_wr(4); tick();
        issue_wr(10); flush_req = 1;
        #1 check("t5_flush_blocks", 32'(issue_fire), 32'h0);
        tick();
        flush_req = 0;
        retire(3);
        #1 check("t5_drain_blocks", 32'(issue_fire), 32'h0);
        tick();
        retire(4);
        #1 check("t5_no_early_done", 32'(drain_done), 32'h0);
        tick();
        WB_reg_en = 0;
        #1 check("t5_drain_done", 32'(drain_done), 32'h1);
        check("t5_still_blocked", 32'(issue_fire), 32'h0);
        tick();
        #1 check("t5_done_once", 32'(drain_done), 32'h0);
        check("t5_resume", 32'(issue_fire), 32'h1);
        tick();
        idle();
        retire(10);
        tick();

        // reset during drain, then ex_ready back-pressure
        idle();
        issue_wr(3); tick();
        issue_wr(4); tick();
        idle(); flush_req = 1; tick();
        flush_req = 0; reset = 1; tick();
        reset = 0;
        #1 check("t6_mask_zero", pending_mask, 32'h0);
        check("t6_no_done", 32'(drain_done), 32'h0);
        check("t6_underflow_clr", 32'(sb_underflow), 32'h0);
        issue_wr(3);
        #1 check("t6_run_fire", 32'(issue_fire), 32'h1);
        tick();
        idle(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 1; ex_ready = 0;
        #1 check("t6_exready_stall", 32'(issue_stall), 32'h1);
        tick();
        idle();
        retire(3);
        tick();

        // randomized traffic on a narrow register range to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            id_valid    = ($urandom_range(0, 3) != 0);
            id_rs1      = 5'($urandom_range(0, 7));
            id_rs2      = 5'($urandom_range(0, 7));
            id_rd       = 5'($urandom_range(0, 7));
            id_use_rs1  = 1'($urandom_range(0, 1));
            id_use_rs2  = 1'($urandom_range(0, 1));
            id_use_rd   = ($urandom_range(0, 4) == 0);
            id_wr_rd    = ($urandom_range(0, 2) != 0);
            ex_ready    = ($urandom_range(0, 4) != 0);
            WB_reg_en   = 1'($urandom_range(0, 1));
            WB_regD_out = 5'($urandom_range(0, 7));
            flush_req   = ($urandom_range(0, 39) == 0);
            reset       = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 0;
        idle();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
